// File: rtl/zxmouse_init_seq_if.sv
// Byte-level link between the init sequencer and the PS/2 host transceiver.
interface zxmouse_init_seq_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_error;
   logic [7:0] rx_data;
   logic       rx_valid;

   // master: the sequencer issuing commands
   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_error, rx_data, rx_valid
   );

   // slave: the transceiver carrying bytes to/from the mouse
   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_error, rx_data, rx_valid
   );
endinterface

// File: rtl/zxmouse_init_seq.sv
// PS/2 mouse init sequencer: reset, IntelliMouse rate knock (200/100/80),
// get ID, enable reporting. Failed steps restart from step 0 until the
// retry budget is spent, then the block parks in FAIL.
module zxmouse_init_seq #(
   parameter int ACK_TIMEOUT = 2_000_000,
   parameter int BAT_TIMEOUT = 40_000_000,
   parameter int RETRIES     = 3
) (
   input  logic                      clk_peripheral,
   input  logic                      reset,
   input  logic                      restart,
   zxmouse_init_seq_if.master        bus,
   output logic                      streaming,
   output logic                      wheel_present,
   output logic                      busy,
   output logic                      error
);

   localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = $clog2(RETRIES + 2);

   localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TIMEOUT);
   localparam logic [TW-1:0] BAT_LIM = TW'(BAT_TIMEOUT);
   localparam logic [RW-1:0] R_LIM   = RW'(RETRIES);
   localparam logic [RW-1:0] R_MAX   = RW'(RETRIES + 1);

   typedef enum logic [2:0] {
      SEND, WAIT_ACK, WAIT_BAT, WAIT_ID0, WAIT_ID, STREAM, FAIL
   } state_t;

   state_t         state, state_nxt;
   logic [3:0]     step, step_nxt;
   logic [RW-1:0]  retry, retry_nxt;
   logic [TW-1:0]  timer;
   logic           wheel_nxt;
   logic           hs;
   logic           fail_ev;

   // Command byte for each step of the sequence
   function automatic logic [7:0] cmd_byte(input logic [3:0] s);
      case (s)
         4'd0:    cmd_byte = 8'hFF;
         4'd1:    cmd_byte = 8'hF3;
         4'd2:    cmd_byte = 8'hC8;
         4'd3:    cmd_byte = 8'hF3;
         4'd4:    cmd_byte = 8'h64;
         4'd5:    cmd_byte = 8'hF3;
         4'd6:    cmd_byte = 8'h50;
         4'd7:    cmd_byte = 8'hF2;
         default: cmd_byte = 8'hF4;
      endcase
   endfunction

   // Retry count after one more failure; stops one past the limit
   function automatic logic [RW-1:0] retry_inc(input logic [RW-1:0] r);
      retry_inc = (r == R_MAX) ? r : r + RW'(1);
   endfunction

   assign hs = (state == SEND) && bus.tx_valid && bus.tx_ready;

   // Next-state decode; restart overrides everything, tx_error beats rx,
   // rx beats a timeout landing in the same cycle
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      retry_nxt = retry;
      wheel_nxt = wheel_present;
      fail_ev   = 1'b0;
      case (state)
         SEND: if (hs) state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (bus.tx_error) fail_ev = 1'b1;
            else if (bus.rx_valid) begin
               if (bus.rx_data == 8'hFA) begin
                  case (step)
                     4'd0: state_nxt = WAIT_BAT;
                     4'd7: state_nxt = WAIT_ID;
                     4'd8: state_nxt = STREAM;
                     default: begin
                        step_nxt  = step + 4'd1;
                        state_nxt = SEND;
                     end
                  endcase
               end else if (bus.rx_data == 8'hFE) begin
                  // resend request: same step, but it still spends a retry
                  retry_nxt = retry_inc(retry);
                  state_nxt = (retry >= R_LIM) ? FAIL : SEND;
               end else fail_ev = 1'b1;
            end else if (timer == ACK_LIM) fail_ev = 1'b1;
         end
         WAIT_BAT: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'hAA) state_nxt = WAIT_ID0;
               else fail_ev = 1'b1;
            end else if (timer == BAT_LIM) fail_ev = 1'b1;
         end
         WAIT_ID0: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'h00) begin
                  step_nxt  = 4'd1;
                  state_nxt = SEND;
               end else fail_ev = 1'b1;
            end else if (timer == ACK_LIM) fail_ev = 1'b1;
         end
         WAIT_ID: begin
            if (bus.rx_valid) begin
               wheel_nxt = (bus.rx_data == 8'h03);
               step_nxt  = 4'd8;
               state_nxt = SEND;
            end else if (timer == ACK_LIM) fail_ev = 1'b1;
         end
         default: ; // STREAM and FAIL only leave on restart/reset
      endcase
      if (fail_ev) begin
         retry_nxt = retry_inc(retry);
         if (retry >= R_LIM) state_nxt = FAIL;
         else begin
            state_nxt = SEND;
            step_nxt  = 4'd0;
            wheel_nxt = 1'b0;
         end
      end
      if (restart) begin
         state_nxt = SEND;
         step_nxt  = 4'd0;
         retry_nxt = '0;
         wheel_nxt = 1'b0;
      end
   end

   // Sequencer state, step, retry count, wheel flag and per-state timer
   always_ff @(posedge clk_peripheral) begin
      if (reset) begin
         state         <= SEND;
         step          <= 4'd0;
         retry         <= '0;
         wheel_present <= 1'b0;
         timer         <= '0;
      end else begin
         state         <= state_nxt;
         step          <= step_nxt;
         retry         <= retry_nxt;
         wheel_present <= wheel_nxt;
         if (restart || state_nxt != state) timer <= '0;
         else if (timer != '1)              timer <= timer + TW'(1);
      end
   end

   // Registered outputs trail the state by one cycle; tx_valid is cut on
   // the handshake so a byte is never offered twice, and on restart so the
   // byte under offer never changes while valid
   always_ff @(posedge clk_peripheral) begin
      if (reset) begin
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= 8'h00;
         streaming    <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
      end else begin
         bus.tx_valid <= (state == SEND) && !hs && !restart;
         bus.tx_data  <= cmd_byte(step);
         streaming    <= (state == STREAM) && !restart;
         error        <= (state == FAIL) && !restart;
         busy         <= restart || !((state == STREAM) || (state == FAIL));
      end
   end

endmodule
